// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding and the
//                oversampling constants. Used by both receiver and transmitter.
//  Contents    : OVERSAMPLE  - ticks per bit period
//                MID_SAMPLE  - tick count at which the start bit is centred
//                uart_rx_state_t - receiver FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Host-side bundle of the UART receiver.
//  Signals     : rxclk_en   - 16x oversample strobe
//                rx         - serial input line (idles high)
//                rdy_clr    - acknowledge pulse, clears rdy and all flags
//                data       - last received word
//                rdy        - word held, not yet acknowledged
//                frame_err  - stop bit of held word sampled low
//                overrun    - a word was lost (sticky)
//                parity_err - parity mismatch on held word
//  Modports    : master - host / line driver side
//                slave  - receiver side
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 rxclk_en;
    logic                 rx;
    logic                 rdy_clr;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    modport master (
        output rxclk_en, rx, rdy_clr,
        input  data, rdy, frame_err, overrun, parity_err
    );

    modport slave (
        input  rxclk_en, rx, rdy_clr,
        output data, rdy, frame_err, overrun, parity_err
    );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//                Reset presets both stages to 1 so an idle-high line reads
//                idle straight out of reset.
//  Ports       : clk - destination clock
//                rst - asynchronous active-high reset
//                i_d - asynchronous input
//                o_q - synchronized output (2 cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampling UART receiver (8N1 by default). Recovers
//                frames from the rx line, advancing only on rxclk_en ticks,
//                and presents each word with ready and error flags.
//  Ports       : clk_50m - system clock
//                rst     - asynchronous active-high reset
//                bus     - uart_rx_if.slave (rxclk_en, rx, rdy_clr in;
//                          data, rdy, frame_err, overrun, parity_err out)
//  Options     : UART_RX_PARITY_EN - when defined, an even parity bit is
//                expected after the data bits (8E1) and checked into
//                parity_err; otherwise parity_err is always 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  wire logic clk_50m,
    input  wire logic rst,
    uart_rx_if.slave  bus
);

    localparam int                   c_idx_w    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(DATA_BITS - 1);
    localparam logic [3:0]           c_cnt_mid  = 4'(MID_SAMPLE);
    localparam logic [3:0]           c_cnt_end  = 4'(OVERSAMPLE - 1);

    logic                 w_rx_s;

    uart_rx_state_t       r_state;
    logic [3:0]           r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_armed;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_parity_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
`endif

    sync_2ff u_sync (
        .clk (clk_50m),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shreg      <= '0;
            r_armed      <= 1'b0;
            r_data       <= '0;
            r_rdy        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
`endif
        end else begin
            // Acknowledge is applied first; a frame completing in the same
            // cycle assigns again below and therefore takes precedence.
            if (bus.rdy_clr) begin
                r_rdy        <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
                r_parity_err <= 1'b0;
            end

            if (bus.rxclk_en) begin
                case (r_state)
                    RX_IDLE: begin
                        // A falling edge only counts once the line has been
                        // seen high, so a stuck-low line never starts frames.
                        if (w_rx_s) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= RX_START;
                            r_cnt   <= '0;
                        end
                    end

                    RX_START: begin
                        if (w_rx_s) begin
                            // Line went back high before mid start bit: glitch.
                            r_state <= RX_IDLE;
                            r_armed <= 1'b1;
                        end else if (r_cnt == c_cnt_mid) begin
                            r_state <= RX_DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end

                    RX_DATA: begin
                        if (r_cnt == c_cnt_end) begin
                            r_shreg[r_idx] <= w_rx_s;
                            r_cnt          <= '0;
                            if (r_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= RX_PARITY;
`else
                                r_state <= RX_STOP;
`endif
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    RX_PARITY: begin
                        if (r_cnt == c_cnt_end) begin
                            r_par_bit <= w_rx_s;
                            r_cnt     <= '0;
                            r_state   <= RX_STOP;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
`endif

                    RX_STOP: begin
                        if (r_cnt == c_cnt_end) begin
                            r_data      <= r_shreg;
                            r_rdy       <= 1'b1;
                            r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (^r_shreg) ^ r_par_bit;
`else
                            r_parity_err <= 1'b0;
`endif
                            // An unacknowledged word is being overwritten,
                            // unless the host acknowledges in this very cycle.
                            r_overrun   <= (r_overrun | r_rdy) & ~bus.rdy_clr;
                            r_cnt       <= '0;
                            r_state     <= RX_IDLE;
                            // A low stop bit leaves the line low: re-arm only
                            // after it has been seen high again.
                            r_armed     <= w_rx_s;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end

                    default: begin
                        r_state <= RX_IDLE;
                        r_armed <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.rdy        = r_rdy;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.parity_err = r_parity_err;

endmodule : uart_rx
`default_nettype wire
